uart_tx_arbiter: RTL

Round-robin scheduler that shares the single MCU_TX serial transmitter among NUM_REQ byte requesters. It latches the granted requester's byte and drives the transmitter enable and data. It then waits for the transmitter's frame-done pulse and enforces an inter-frame guard gap. A watchdog aborts a frame whose done pulse never arrives. The block sits between on-chip byte sources and the TX stage of the top-level loopback design.

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin byte scheduler in front of the MCU_TX serial
//           transmitter, with an inter-frame guard gap and a frame watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 20000,
    parameter int TMR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_ena,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   err,
    output logic                   busy
);

    localparam int                PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TMR_W-1:0]  C_TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  C_GAP_LAST = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0]  C_PTR_RST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [NUM_REQ-1:0] w_ack_nxt, w_done_nxt, w_grant_nxt;
    logic               w_tx_ena_nxt, w_err_nxt;
    logic [7:0]         w_tx_data_nxt;
    logic               w_found;
    logic [PTR_W-1:0]   w_sel;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    // Cyclic search starting just after the last owner; the last owner is
    // examined last, which is what makes a held request wait its turn.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[wrap_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_timer_nxt   = r_timer;
        w_ack_nxt     = '0;
        w_done_nxt    = '0;
        w_err_nxt     = 1'b0;
        w_grant_nxt   = grant;
        w_tx_ena_nxt  = tx_ena;
        w_tx_data_nxt = tx_data;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_tx_data_nxt = req_data[int'(w_sel)*8 +: 8];
                    w_grant_nxt   = NUM_REQ'(1) << w_sel;
                    w_ack_nxt     = NUM_REQ'(1) << w_sel;
                    w_tx_ena_nxt  = 1'b1;
                    w_ptr_nxt     = w_sel;
                    w_timer_nxt   = '0;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                // tx_done is tested first so a same-cycle timeout still completes normally
                if (tx_done || (r_timer == C_TMO_LAST)) begin
                    w_done_nxt   = tx_done ? grant : '0;
                    w_err_nxt    = ~tx_done;
                    w_tx_ena_nxt = 1'b0;
                    w_grant_nxt  = '0;
                    w_timer_nxt  = '0;
                    if (GAP_CYCLES == 0) w_state_nxt = S_IDLE;
                    else                 w_state_nxt = S_GAP;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_GAP: begin
                if (r_timer == C_GAP_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= C_PTR_RST;
            r_timer <= '0;
            ack     <= '0;
            done    <= '0;
            grant   <= '0;
            err     <= 1'b0;
            tx_ena  <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_timer <= w_timer_nxt;
            ack     <= w_ack_nxt;
            done    <= w_done_nxt;
            grant   <= w_grant_nxt;
            err     <= w_err_nxt;
            tx_ena  <= w_tx_ena_nxt;
            tx_data <= w_tx_data_nxt;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire
